// File: rtl/seg_pkg.sv
// Shared glyph constants and helpers for the 7-segment scan decoder.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam logic [3:0] INVALID = 4'hF;
    localparam logic [6:0] BLANK   = 7'h7F;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;

    function automatic logic [3:0] zero_count(input logic [7:0] a);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, ~a[i]};
        return n;
    endfunction

    function automatic logic [2:0] zero_pos(input logic [7:0] a);
        logic [2:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (!a[i]) p = 3'(i);
        return p;
    endfunction

    // An unreadable digit poisons the whole two-digit value.
    function automatic logic [6:0] calc_time(input logic [3:0] tens,
                                             input logic [3:0] units);
        if (tens == INVALID || units == INVALID) return 7'd127;
        return 7'(tens) * 7'd10 + 7'(units);
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Glyph lookup bundle between the scan decoder and the glyph table.
// master drives the segment pattern, slave returns code and invalid.
interface seg_scan_decoder_if;
    logic [6:0] seg;
    logic [3:0] code;
    logic       invalid;

    modport master (output seg, input code, input invalid);
    modport slave  (input seg, output code, output invalid);
endinterface

// File: rtl/seg_glyph_decode.sv
// Combinational 7-segment glyph to digit code lookup.
// Blank reads as 0; unknown patterns return INVALID.
module seg_glyph_decode
    import seg_pkg::*;
(
    seg_scan_decoder_if.slave glyph
);

    // Map each known segment pattern to its digit value
    always_comb begin
        glyph.code    = INVALID;
        glyph.invalid = 1'b0;
        unique case (glyph.seg)
            GLYPH_0, BLANK: glyph.code = 4'd0;
            GLYPH_1:        glyph.code = 4'd1;
            GLYPH_2:        glyph.code = 4'd2;
            GLYPH_3:        glyph.code = 4'd3;
            GLYPH_4:        glyph.code = 4'd4;
            GLYPH_5:        glyph.code = 4'd5;
            GLYPH_6:        glyph.code = 4'd6;
            GLYPH_7:        glyph.code = 4'd7;
            GLYPH_8:        glyph.code = 4'd8;
            GLYPH_9:        glyph.code = 4'd9;
            default: begin
                glyph.code    = INVALID;
                glyph.invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers countdown values from a scanned 8-digit 7-segment display.
// Digits are debounced, collected per anode, and published per frame.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [7:0] AN,
    input  logic [7:0] SIG_C,
    output logic [6:0] main_rest_time,
    output logic [6:0] sub_rest_time,
    output logic [3:0] state_code,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       an_err,
    output logic       stale
);

    localparam logic [7:0]  STABLE = 8'(STABLE_CYCLES);
    localparam logic [20:0] TMO    = 21'(TIMEOUT_CYCLES);

    logic [7:0]  an_q, an_p, sig_q, sig_p;
    logic [7:0]  cnt, cnt_nxt;
    logic        same, fire, accept, reject, done;
    logic [3:0]  nzero;
    logic [2:0]  pos;
    logic [3:0]  digits [8];
    logic [7:0]  seen;
    logic        bad;
    logic [20:0] tcnt;

    seg_scan_decoder_if gl ();

    assign gl.seg = sig_q[6:0];

    seg_glyph_decode u_dec (.glyph(gl));

    // Input sample register plus the previous sample for run detection
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            an_q  <= 8'hFF;
            sig_q <= 8'hFF;
            an_p  <= 8'hFF;
            sig_p <= 8'hFF;
        end else begin
            an_q  <= AN;
            sig_q <= SIG_C;
            an_p  <= an_q;
            sig_p <= sig_q;
        end
    end

    // Run length, fire once when a run first reaches the threshold
    always_comb begin
        same    = (an_q == an_p) && (sig_q == sig_p);
        cnt_nxt = 8'd1;
        if (same) cnt_nxt = (cnt == STABLE) ? STABLE : cnt + 8'd1;
        fire    = (cnt_nxt == STABLE) && (!same || cnt != STABLE);
        nzero   = zero_count(an_q);
        pos     = zero_pos(an_q);
        accept  = fire && (nzero == 4'd1);
        reject  = fire && (nzero > 4'd1);
        done    = (seen == 8'hFF);
    end

    // Stability counter register
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) cnt <= '0;
        else        cnt <= cnt_nxt;
    end

    // Digit buffer and frame collection; a digit landing on the
    // completion cycle starts the next frame
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 8; i++) digits[i] <= '0;
            seen   <= '0;
            bad    <= 1'b0;
            an_err <= 1'b0;
        end else begin
            an_err <= reject;
            if (accept) digits[pos] <= gl.code;
            if (done) begin
                seen <= accept ? (8'h01 << pos) : 8'h00;
                bad  <= accept && gl.invalid;
            end else if (accept) begin
                seen <= seen | (8'h01 << pos);
                bad  <= bad | gl.invalid;
            end
        end
    end

    // Publish a completed frame
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            main_rest_time <= '0;
            sub_rest_time  <= '0;
            state_code     <= '0;
            frame_valid    <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            frame_valid <= done;
            frame_err   <= done && bad;
            if (done) begin
                main_rest_time <= calc_time(digits[1], digits[0]);
                sub_rest_time  <= calc_time(digits[3], digits[2]);
                state_code     <= digits[4];
            end
        end
    end

    // Saturating age of the last frame drives the stale flag
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            tcnt  <= '0;
            stale <= 1'b0;
        end else if (done) begin
            tcnt  <= '0;
            stale <= 1'b0;
        end else if (tcnt != TMO) begin
            tcnt  <= tcnt + 21'd1;
            stale <= (tcnt + 21'd1 == TMO);
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder and its glyph table.
// Directed vectors with hand-computed expectations.
module tb_seg_scan_decoder;

    localparam int TMO = 300;

    logic       clk = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] AN = 8'hFF;
    logic [7:0] SIG_C = 8'hFF;
    logic [6:0] main_rest_time, sub_rest_time;
    logic [3:0] state_code;
    logic       frame_valid, frame_err, an_err, stale;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int ae_cnt = 0;
    logic fe_last = 1'b0;
    logic stale_at_fv = 1'b0;
    logic prev_stale_at_fv = 1'b0;
    logic prev_stale = 1'b0;

    always #5 clk = ~clk;

    seg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .Reset(Reset), .AN(AN), .SIG_C(SIG_C),
        .main_rest_time(main_rest_time), .sub_rest_time(sub_rest_time),
        .state_code(state_code), .frame_valid(frame_valid),
        .frame_err(frame_err), .an_err(an_err), .stale(stale)
    );

    seg_scan_decoder_if gif ();
    seg_glyph_decode u_gd (.glyph(gif));

    // Pulse monitor sampled on the falling edge
    always @(negedge clk) begin
        if (Reset) begin
            if (frame_valid) begin
                fv_cnt++;
                fe_last = frame_err;
                stale_at_fv = stale;
                prev_stale_at_fv = prev_stale;
            end
            if (an_err) ae_cnt++;
            prev_stale = stale;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] an, input logic [7:0] sig,
                         input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            AN = an;
            SIG_C = sig;
        end
    endtask

    task automatic digit(input int p, input logic [63:0] sigs,
                         input int cycles);
        logic [7:0] an;
        an = ~(8'h01 << p);
        drive(an, sigs[8*p +: 8], cycles);
    endtask

    task automatic idle(input int cycles);
        drive(8'hFF, 8'hFF, cycles);
    endtask

    task automatic scan_frame(input logic [63:0] sigs);
        for (int p = 0; p < 8; p++) digit(p, sigs, 8);
        idle(2);
    endtask

    typedef struct {
        logic [6:0] seg;
        logic [3:0] code;
        logic       inv;
    } glyph_vec_t;

    typedef struct {
        logic [63:0] sigs;
        logic [6:0]  main_t;
        logic [6:0]  sub_t;
        logic [3:0]  state;
        logic        err;
    } frame_vec_t;

    glyph_vec_t gv [14];
    frame_vec_t fvv [5];

    initial begin
        int base;
        int abase;

        gv[0]  = '{7'h40, 4'd0, 1'b0};
        gv[1]  = '{7'h79, 4'd1, 1'b0};
        gv[2]  = '{7'h24, 4'd2, 1'b0};
        gv[3]  = '{7'h30, 4'd3, 1'b0};
        gv[4]  = '{7'h19, 4'd4, 1'b0};
        gv[5]  = '{7'h12, 4'd5, 1'b0};
        gv[6]  = '{7'h02, 4'd6, 1'b0};
        gv[7]  = '{7'h78, 4'd7, 1'b0};
        gv[8]  = '{7'h00, 4'd8, 1'b0};
        gv[9]  = '{7'h10, 4'd9, 1'b0};
        gv[10] = '{7'h7F, 4'd0, 1'b0};
        gv[11] = '{7'h7E, 4'hF, 1'b1};
        gv[12] = '{7'h3F, 4'hF, 1'b1};
        gv[13] = '{7'h01, 4'hF, 1'b1};

        fvv[0] = '{64'hFFFF_FFB0_F9C0_A492, 7'd25, 7'd10, 4'd3, 1'b0};
        fvv[1] = '{64'hFFFF_FF82_80F8_9090, 7'd99, 7'd87, 4'd6, 1'b0};
        fvv[2] = '{64'hFFFF_FFFF_C099_F9FE, 7'd127, 7'd4, 4'd0, 1'b1};
        fvv[3] = '{64'h7F7F_7F12_3010_0002, 7'd86, 7'd39, 4'd5, 1'b0};
        fvv[4] = '{64'hFFFF_FFFE_FFFF_FFFF, 7'd0, 7'd0, 4'hF, 1'b1};

        for (int i = 0; i < 14; i++) begin
            gif.seg = gv[i].seg;
            #1;
            chk($sformatf("glyph_code[%0d]", i), 32'(gif.code), 32'(gv[i].code));
            chk($sformatf("glyph_inv[%0d]", i), 32'(gif.invalid), 32'(gv[i].inv));
        end

        repeat (3) @(negedge clk);
        chk("rst_main", 32'(main_rest_time), 0);
        chk("rst_sub", 32'(sub_rest_time), 0);
        chk("rst_state", 32'(state_code), 0);
        chk("rst_fv", 32'(frame_valid), 0);
        chk("rst_stale", 32'(stale), 0);
        chk("rst_anerr", 32'(an_err), 0);
        Reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            base = fv_cnt;
            scan_frame(fvv[i].sigs);
            chk($sformatf("frm%0d_fv", i), 32'(fv_cnt - base), 1);
            chk($sformatf("frm%0d_main", i), 32'(main_rest_time), 32'(fvv[i].main_t));
            chk($sformatf("frm%0d_sub", i), 32'(sub_rest_time), 32'(fvv[i].sub_t));
            chk($sformatf("frm%0d_state", i), 32'(state_code), 32'(fvv[i].state));
            chk($sformatf("frm%0d_err", i), 32'(fe_last), 32'(fvv[i].err));
        end

        base = fv_cnt;
        for (int p = 0; p < 7; p++) digit(p, fvv[0].sigs, 8);
        digit(7, fvv[0].sigs, 3);
        idle(10);
        chk("short_digit_fv", 32'(fv_cnt - base), 0);
        digit(7, fvv[0].sigs, 4);
        idle(4);
        chk("exact4_fv", 32'(fv_cnt - base), 1);
        chk("exact4_main", 32'(main_rest_time), 25);

        abase = ae_cnt;
        drive(8'hFC, 8'h92, 3);
        idle(8);
        chk("anerr_short", 32'(ae_cnt - abase), 0);
        drive(8'hFC, 8'h92, 12);
        idle(8);
        chk("anerr_once", 32'(ae_cnt - abase), 1);
        base = fv_cnt;
        for (int p = 2; p < 8; p++) digit(p, fvv[1].sigs, 8);
        idle(4);
        chk("anerr_noseen", 32'(fv_cnt - base), 0);
        digit(0, fvv[1].sigs, 8);
        digit(1, fvv[1].sigs, 8);
        idle(2);
        chk("anerr_frame", 32'(fv_cnt - base), 1);

        idle(250);
        chk("stale_early", 32'(stale), 0);
        idle(70);
        chk("stale_set", 32'(stale), 1);
        base = fv_cnt;
        scan_frame(fvv[0].sigs);
        chk("stale_fv", 32'(fv_cnt - base), 1);
        chk("stale_before_fv", 32'(prev_stale_at_fv), 1);
        chk("stale_on_fv", 32'(stale_at_fv), 0);
        chk("stale_after", 32'(stale), 0);

        scan_frame(fvv[1].sigs);
        chk("prerst_main", 32'(main_rest_time), 99);
        for (int p = 0; p < 5; p++) digit(p, fvv[0].sigs, 8);
        @(negedge clk);
        Reset = 1'b0;
        #1;
        chk("async_rst_main", 32'(main_rest_time), 0);
        chk("async_rst_sub", 32'(sub_rest_time), 0);
        chk("async_rst_state", 32'(state_code), 0);
        idle(3);
        Reset = 1'b1;
        base = fv_cnt;
        for (int k = 5; k < 8; k++) digit(k, fvv[0].sigs, 8);
        idle(2);
        chk("rst_partial_fv", 32'(fv_cnt - base), 0);
        chk("rst_partial_main", 32'(main_rest_time), 0);
        for (int k = 0; k < 5; k++) digit(k, fvv[0].sigs, 8);
        idle(2);
        chk("rst_frame_fv", 32'(fv_cnt - base), 1);
        chk("rst_frame_main", 32'(main_rest_time), 25);
        chk("rst_frame_sub", 32'(sub_rest_time), 10);
        chk("rst_frame_state", 32'(state_code), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, 4, consecutive identical (AN,SIG_C) samples needed to accept a digit (range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, 65536, cycles without a completed frame before stale asserts (range 1..2^20).
REQ-003 SHALL have port clk  in  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port AN  in  8  scanned digit anodes, active-low, one-hot-low when a digit is lit.
REQ-006 SHALL have port SIG_C  in  8  segments active-low, bit7=dp, bits6..0={g,f,e,d,c,b,a}.
REQ-007 SHALL have port main_rest_time  out  7  main countdown value, tens(AN[1])*10+units(AN[0]).
REQ-008 SHALL have port sub_rest_time  out  7  sub countdown value, tens(AN[3])*10+units(AN[2]).
REQ-009 SHALL have port state_code  out  4  decoded code of digit AN[4].
REQ-010 SHALL have port frame_valid  out  1  one-cycle pulse when all outputs update.
REQ-011 SHALL have port frame_err  out  1  one-cycle pulse, coincident with frame_valid, if the frame held an invalid glyph.
REQ-012 SHALL have port an_err  out  1  one-cycle pulse per rejected multi-low AN sample.
REQ-013 SHALL have port stale  out  1  level, high while no frame completed within TIMEOUT_CYCLES.

Function
REQ-014 SHALL register AN and SIG_C once (one-stage input register) before any decoding.
REQ-015 SHALL compare each registered sample to the previous one; stability counter increments when equal, reloads 1 when different, saturates at STABLE_CYCLES.
REQ-016 SHALL accept a digit exactly once per stable run, on the cycle the counter reaches STABLE_CYCLES, only if AN has exactly one zero bit.
REQ-017 SHALL ignore samples with AN=8'hFF (blanking gap) without error.
REQ-018 SHALL pulse an_err, once per stable run, when a stable AN has two or more zero bits, and SHALL discard that sample.
REQ-019 SHALL decode SIG_C[6:0] via glyph table: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 7F (blank)->0; any other pattern ->4'hF and marks the frame bad; dp ignored.
REQ-020 SHALL store accepted codes in an 8-entry digit buffer indexed by the zero position of AN and set the matching bit of an 8-bit seen mask.
REQ-021 SHALL treat a re-accepted position already in seen mask as overwrite (latest value wins), not a new frame.
REQ-022 SHALL complete a frame the cycle after seen mask becomes 8'hFF: update outputs, pulse frame_valid, pulse frame_err if bad, clear seen mask and bad flag in the same cycle.
REQ-023 SHALL compute each time as tens*10+units in 7 bits; a code of 4'hF in tens or units yields 7'd127 for that time; max valid result 99.
REQ-024 SHALL hold main_rest_time, sub_rest_time, state_code between frames.
REQ-025 SHALL count cycles since last frame_valid (saturating); stale SHALL rise when the count reaches TIMEOUT_CYCLES and fall on the next frame_valid cycle.
REQ-026 Digit acceptance on the same cycle as frame completion SHALL count toward the next frame.
REQ-027 Latency: stable-run start to digit acceptance = STABLE_CYCLES+1 cycles; last acceptance to frame_valid = 1 cycle.

Reset
REQ-028 On Reset low SHALL asynchronously clear: times to 0, state_code 0, all pulses 0, stale 0, seen mask, bad flag, stability and timeout counters, digit buffer, input registers to 8'hFF.
REQ-029 Reset mid-frame SHALL discard partial frame; first frame after release requires all 8 positions anew.

Structure
REQ-030 SHALL place glyph constants, code 4'hF INVALID, and BLANK pattern in shared package seg_pkg.
REQ-031 SHALL implement glyph lookup as combinational sub-module seg_glyph_decode (7-bit in, 4-bit code + invalid flag out).

Verification
REQ-032 Scan 8 digits, 8 cycles each, AN[1:0]="2","5", AN[3:2]="1","0", AN[4]="3" -> frame_valid once, main=25, sub=10, state_code=3, frame_err=0.
REQ-033 Digit held only 3 cycles (STABLE_CYCLES=4) -> not accepted, no frame_valid.
REQ-034 AN=8'hFC stable 4 cycles -> one an_err pulse, seen mask unchanged.
REQ-035 SIG_C[6:0]=7'h7E on AN[0] within frame -> frame_valid with frame_err, main=127.
REQ-036 No scanning for TIMEOUT_CYCLES -> stale=1; next complete frame -> stale=0 on frame_valid cycle.
REQ-037 Reset asserted after 5 digits, released, 8 further digits -> exactly one frame_valid, outputs 0 until then.
